// File: rtl/fetch_instruction_buffer.sv
// -----------------------------------------------------------------------------
// fetch_instruction_buffer
//
// Circular instruction queue between the 5-wide fetch/branch-prediction stage
// and the 3-wide decode stage. Each entry carries the instruction, its PC and
// the prediction metadata (predicted-taken, JALR flag, global history).
//
// Ports
//   clk              clock, all state updates on the rising edge
//   reset            asynchronous active-low reset
//   flush_i          synchronous clear of every entry (redirect)
//   in_valid_i       per-lane valid, thermometer-coded from lane 0
//   in_pc_i          PC per fetch lane
//   in_instr_i       instruction per fetch lane
//   in_jump_i        predicted-taken per fetch lane
//   in_jalr_i        JALR flag per fetch lane
//   in_ghist_i       global history snapshot per fetch lane
//   fetch_ready_o    room for a full 5-wide group this cycle
//   out_valid_o      thermometer valid for decode lanes 0..2
//   out_pc_o .. out_ghist_o   entries head, head+1, head+2
//   decode_ready_i   decode takes every asserted out_valid_o lane
//   count_o          current occupancy
// -----------------------------------------------------------------------------
module fetch_instruction_buffer #(
  parameter int size        = 32,
  parameter int DEPTH       = 16,
  parameter int ENTRIES     = 32,
  parameter int INDEX_WIDTH = $clog2(ENTRIES),
  parameter int PTR_W       = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush_i,
  input  logic [4:0]                  in_valid_i,
  input  logic [4:0][size-1:0]        in_pc_i,
  input  logic [4:0][size-1:0]        in_instr_i,
  input  logic [4:0]                  in_jump_i,
  input  logic [4:0]                  in_jalr_i,
  input  logic [4:0][INDEX_WIDTH:0]   in_ghist_i,
  output logic                        fetch_ready_o,
  output logic [2:0]                  out_valid_o,
  output logic [2:0][size-1:0]        out_pc_o,
  output logic [2:0][size-1:0]        out_instr_o,
  output logic [2:0]                  out_jump_o,
  output logic [2:0]                  out_jalr_o,
  output logic [2:0][INDEX_WIDTH:0]   out_ghist_o,
  input  logic                        decode_ready_i,
  output logic [PTR_W:0]              count_o
);

  localparam int FETCH_W = 5;
  localparam int DEC_W   = 3;
  localparam int CNT_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FETCH_W_C = CNT_W'(FETCH_W);

  typedef struct packed {
    logic [size-1:0]      pc;
    logic [size-1:0]      instr;
    logic                 jump;
    logic                 jalr;
    logic [INDEX_WIDTH:0] ghist;
  } entry_t;

  entry_t mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq_en;
  logic             deq_en;
  logic [2:0]       enq_n;
  logic [1:0]       deq_n;

  logic [FETCH_W-1:0][PTR_W-1:0] wr_idx;
  logic [DEC_W-1:0][PTR_W-1:0]   rd_idx;

  // Readiness depends only on registered occupancy, so decode stalls never
  // reach back into fetch combinationally.
  assign fetch_ready_o = (DEPTH_C - count_q) >= FETCH_W_C;

  assign enq_en = fetch_ready_o && !flush_i;
  assign enq_n  = enq_en ? 3'($countones(in_valid_i)) : 3'd0;

  // out_valid_o is never wider than the occupancy, so deq can't underflow.
  always_comb begin
    for (int k = 0; k < DEC_W; k++) begin
      out_valid_o[k] = count_q > CNT_W'(k);
    end
  end

  assign deq_en = decode_ready_i && !flush_i;
  assign deq_n  = deq_en ? 2'($countones(out_valid_o)) : 2'd0;

  // Per-lane storage indices; truncation to PTR_W bits gives the wrap.
  always_comb begin
    for (int k = 0; k < FETCH_W; k++) begin
      wr_idx[k] = tail_q + PTR_W'(k);
    end
    for (int k = 0; k < DEC_W; k++) begin
      rd_idx[k] = head_q + PTR_W'(k);
    end
  end

  // Head entries are read straight from storage; no enqueue bypass.
  always_comb begin
    for (int k = 0; k < DEC_W; k++) begin
      out_pc_o[k]    = mem_q[rd_idx[k]].pc;
      out_instr_o[k] = mem_q[rd_idx[k]].instr;
      out_jump_o[k]  = mem_q[rd_idx[k]].jump;
      out_jalr_o[k]  = mem_q[rd_idx[k]].jalr;
      out_ghist_o[k] = mem_q[rd_idx[k]].ghist;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_n);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + CNT_W'(enq_n) - CNT_W'(deq_n);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage has no reset; validity is carried entirely by
  // count_q, which keeps the array a plain RAM-style write port.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (enq_en && in_valid_i[k]) begin
        mem_q[wr_idx[k]] <= '{pc:    in_pc_i[k],
                              instr: in_instr_i[k],
                              jump:  in_jump_i[k],
                              jalr:  in_jalr_i[k],
                              ghist: in_ghist_i[k]};
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_fetch_instruction_buffer.sv
// -----------------------------------------------------------------------------
// tb_fetch_instruction_buffer
//
// Bench for fetch_instruction_buffer with default parameters (DEPTH 16,
// 6-bit history). A queue-based reference model tracks the buffer contents;
// a negedge compare process checks every output against it, and directed
// sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_instruction_buffer;

  localparam int DEPTH = 16;
  localparam int HW    = 6;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic          jump;
    logic          jalr;
    logic [HW-1:0] ghist;
  } ent_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush_i;
  logic [4:0]          in_valid_i;
  logic [4:0][31:0]    in_pc_i;
  logic [4:0][31:0]    in_instr_i;
  logic [4:0]          in_jump_i;
  logic [4:0]          in_jalr_i;
  logic [4:0][HW-1:0]  in_ghist_i;
  logic                fetch_ready_o;
  logic [2:0]          out_valid_o;
  logic [2:0][31:0]    out_pc_o;
  logic [2:0][31:0]    out_instr_o;
  logic [2:0]          out_jump_o;
  logic [2:0]          out_jalr_o;
  logic [2:0][HW-1:0]  out_ghist_o;
  logic                decode_ready_i;
  logic [4:0]          count_o;

  int   n_vec = 0;
  int   n_err = 0;
  ent_t mq[$];

  fetch_instruction_buffer dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_pc_i        (in_pc_i),
    .in_instr_i     (in_instr_i),
    .in_jump_i      (in_jump_i),
    .in_jalr_i      (in_jalr_i),
    .in_ghist_i     (in_ghist_i),
    .fetch_ready_o  (fetch_ready_o),
    .out_valid_o    (out_valid_o),
    .out_pc_o       (out_pc_o),
    .out_instr_o    (out_instr_o),
    .out_jump_o     (out_jump_o),
    .out_jalr_o     (out_jalr_o),
    .out_ghist_o    (out_ghist_o),
    .decode_ready_i (decode_ready_i),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of entries updated from the specification's
  // rules (room for 5 -> accept group; decode takes min(occupancy,3)).
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
    end else begin
      assert ((in_valid_i & (in_valid_i + 5'd1)) == 5'd0)
        else $error("in_valid_i not thermometer-coded: %b", in_valid_i);
      if (flush_i) begin
        mq.delete();
      end else begin
        bit room;
        int take;
        room = (DEPTH - mq.size()) >= 5;
        take = decode_ready_i ? ((mq.size() < 3) ? mq.size() : 3) : 0;
        for (int i = 0; i < take; i++) void'(mq.pop_front());
        if (room) begin
          for (int k = 0; k < 5; k++) begin
            if (in_valid_i[k]) begin
              mq.push_back('{pc: in_pc_i[k], instr: in_instr_i[k], jump: in_jump_i[k],
                             jalr: in_jalr_i[k], ghist: in_ghist_i[k]});
            end
          end
        end
      end
    end
  end

  // Compare process: outputs depend only on registered state, so the
  // negedge sees a stable, fully-updated picture.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      int n;
      n = mq.size();
      check("count", 64'(count_o), 64'(n));
      check("fetch_ready", 64'(fetch_ready_o), 64'((DEPTH - n) >= 5));
      for (int k = 0; k < 3; k++) begin
        check($sformatf("valid[%0d]", k), 64'(out_valid_o[k]), 64'(n > k));
        if (n > k) begin
          check($sformatf("pc[%0d]", k),    64'(out_pc_o[k]),    64'(mq[k].pc));
          check($sformatf("instr[%0d]", k), 64'(out_instr_o[k]), 64'(mq[k].instr));
          check($sformatf("jump[%0d]", k),  64'(out_jump_o[k]),  64'(mq[k].jump));
          check($sformatf("jalr[%0d]", k),  64'(out_jalr_o[k]),  64'(mq[k].jalr));
          check($sformatf("ghist[%0d]", k), 64'(out_ghist_o[k]), 64'(mq[k].ghist));
        end
      end
    end
  end

  task automatic drive(input logic [4:0] v, input logic [31:0] base,
                       input logic [4:0] j, input logic [4:0] jr);
    in_valid_i = v;
    in_jump_i  = j;
    in_jalr_i  = jr;
    for (int k = 0; k < 5; k++) begin
      in_pc_i[k]    = base + 32'(4 * k);
      in_instr_i[k] = ~(base + 32'(4 * k));
      in_ghist_i[k] = in_pc_i[k][7:2];
    end
  endtask

  task automatic idle();
    in_valid_i = 5'b0;
    in_jump_i  = 5'b0;
    in_jalr_i  = 5'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nxt;
    bit          room;

    reset          = 1'b0;
    flush_i        = 1'b0;
    decode_ready_i = 1'b0;
    drive(5'b0, 32'h0, 5'b0, 5'b0);

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst out_valid", 64'(out_valid_o), 64'h0);
    check("rst fetch_ready", 64'(fetch_ready_o), 64'h1);
    check("rst count", 64'(count_o), 64'h0);

    // Single group, then two decode cycles.
    tick();
    drive(5'b11111, 32'h100, 5'b0, 5'b0);
    tick();
    idle();
    @(negedge clk);
    check("sg count", 64'(count_o), 64'd5);
    check("sg valid", 64'(out_valid_o), 64'b111);
    check("sg pc0", 64'(out_pc_o[0]), 64'h100);
    check("sg pc1", 64'(out_pc_o[1]), 64'h104);
    check("sg pc2", 64'(out_pc_o[2]), 64'h108);
    decode_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("sg2 valid", 64'(out_valid_o), 64'b011);
    check("sg2 pc0", 64'(out_pc_o[0]), 64'h10C);
    check("sg2 pc1", 64'(out_pc_o[1]), 64'h110);
    tick();
    decode_ready_i = 1'b0;
    @(negedge clk);
    check("sg3 count", 64'(count_o), 64'd0);
    check("sg3 valid", 64'(out_valid_o), 64'b000);

    // Backpressure: three groups fill to 15, a fourth is dropped.
    tick();
    for (int g = 0; g < 4; g++) begin
      drive(5'b11111, 32'h200 + 32'(g * 20), 5'b0, 5'b0);
      tick();
    end
    idle();
    @(negedge clk);
    check("bp count", 64'(count_o), 64'd15);
    check("bp fetch_ready", 64'(fetch_ready_o), 64'd0);
    check("bp head pc", 64'(out_pc_o[0]), 64'h200);
    decode_ready_i = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("bp drained", 64'(count_o), 64'd0);

    // Wrap: 5-wide pushes against 3-wide pops; fetch holds PC on a drop.
    tick();
    nxt = 32'h1000;
    for (int c = 0; c < 20; c++) begin
      drive(5'b11111, nxt, 5'b10000, 5'b0);
      room = (DEPTH - mq.size()) >= 5;
      tick();
      if (room) nxt += 32'h14;
    end
    idle();
    decode_ready_i = 1'b0;
    @(negedge clk);
    check("wrap count", 64'(count_o), 64'd13);
    check("wrap head pc", 64'(out_pc_o[0]), 64'h10E4);
    decode_ready_i = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("wrap drained", 64'(count_o), 64'd0);

    // Flush with simultaneous enqueue and dequeue at count 7.
    tick();
    decode_ready_i = 1'b0;
    drive(5'b11111, 32'h2000, 5'b0, 5'b0);
    tick();
    drive(5'b00011, 32'h3000, 5'b0, 5'b0);
    tick();
    @(negedge clk);
    check("pre-flush count", 64'(count_o), 64'd7);
    drive(5'b11111, 32'h4000, 5'b0, 5'b0);
    flush_i        = 1'b1;
    decode_ready_i = 1'b1;
    tick();
    flush_i        = 1'b0;
    decode_ready_i = 1'b0;
    idle();
    @(negedge clk);
    check("flush count", 64'(count_o), 64'd0);
    check("flush valid", 64'(out_valid_o), 64'b000);
    repeat (2) tick();
    drive(5'b00001, 32'h5000, 5'b0, 5'b0);
    tick();
    idle();
    @(negedge clk);
    check("post-flush pc0", 64'(out_pc_o[0]), 64'h5000);
    check("post-flush count", 64'(count_o), 64'd1);
    decode_ready_i = 1'b1;
    tick();
    decode_ready_i = 1'b0;

    // Partial group with metadata.
    drive(5'b00011, 32'h6000, 5'b00010, 5'b0);
    in_ghist_i[0] = 6'h05;
    in_ghist_i[1] = 6'h2A;
    tick();
    drive(5'b00111, 32'h7000, 5'b0, 5'b00100);
    tick();
    idle();
    @(negedge clk);
    check("md valid", 64'(out_valid_o), 64'b111);
    check("md jump1", 64'(out_jump_o[1]), 64'd1);
    check("md ghist1", 64'(out_ghist_o[1]), 64'h2A);
    check("md jump0", 64'(out_jump_o[0]), 64'd0);
    check("md ghist0", 64'(out_ghist_o[0]), 64'h05);
    check("md count", 64'(count_o), 64'd5);

    // Asynchronous reset mid-operation.
    #3 reset = 1'b0;
    #1;
    check("arst count", 64'(count_o), 64'd0);
    check("arst valid", 64'(out_valid_o), 64'b000);
    check("arst fetch_ready", 64'(fetch_ready_o), 64'd1);
    tick();
    reset = 1'b1;
    drive(5'b01111, 32'h8000, 5'b0, 5'b0);
    tick();
    idle();
    decode_ready_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("final count", 64'(count_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
